// File: rtl/cook_pkg.sv
// cook_pkg
// Shared definitions for the microwave cook controller: the cook state
// encoding, BCD limits for keypad entry, and the nibble positions of the
// MM:SS fields inside the 16-bit preset word.
//
// Preset layout, MSB first: {min_tens, min_ones, sec_tens, sec_ones}.

package cook_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_COOKING = 3'd3,
        ST_PAUSED  = 3'd4,
        ST_CLEAR   = 3'd5,
        ST_DONE    = 3'd6
    } cook_state_t;

    localparam logic [3:0] MAX_DIGIT    = 4'd9;
    localparam logic [3:0] MAX_SEC_TENS = 4'd5;

    // LSB position of each BCD field in the preset word
    localparam int MIN_TENS_LSB = 12;
    localparam int MIN_ONES_LSB = 8;
    localparam int SEC_TENS_LSB = 4;
    localparam int SEC_ONES_LSB = 0;

    // A keypad code is usable only if it is a real decimal digit
    function automatic logic bcd_digit_ok(input logic [3:0] d);
        return (d <= MAX_DIGIT);
    endfunction

endpackage

// File: rtl/cook_entry_reg.sv
// cook_entry_reg
// Four-digit BCD entry register for the MM:SS cook preset. New digits enter
// at sec_ones and every existing digit moves one place left; the old
// min_tens digit is discarded.
//
// Ports:
//   clk          system clock
//   clrn         asynchronous active-low reset
//   shift        request to shift key digit in (ignored if digit is not BCD)
//   clear        synchronous clear of the whole preset (wins over shift)
//   digit        keypad digit
//   preset       current preset {min_tens, min_ones, sec_tens, sec_ones}
//   digit_ok     digit is a valid BCD value (0..9)
//   nonzero      preset is not 00:00
//   sec_tens_ok  sec_tens field is 0..5, i.e. a legal seconds value

module cook_entry_reg (
    input  logic        clk,
    input  logic        clrn,
    input  logic        shift,
    input  logic        clear,
    input  logic [3:0]  digit,
    output logic [15:0] preset,
    output logic        digit_ok,
    output logic        nonzero,
    output logic        sec_tens_ok
);
    import cook_pkg::*;

    assign digit_ok    = bcd_digit_ok(digit);
    assign nonzero     = |preset;
    assign sec_tens_ok = (preset[SEC_TENS_LSB +: 4] <= MAX_SEC_TENS);

    // Preset storage: clear has priority so a stop pressed together with a
    // key leaves the register empty rather than holding the new digit.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            preset <= 16'h0000;
        end else if (clear) begin
            preset <= 16'h0000;
        end else if (shift && digit_ok) begin
            preset[MIN_TENS_LSB +: 4] <= preset[MIN_ONES_LSB +: 4];
            preset[MIN_ONES_LSB +: 4] <= preset[SEC_TENS_LSB +: 4];
            preset[SEC_TENS_LSB +: 4] <= preset[SEC_ONES_LSB +: 4];
            preset[SEC_ONES_LSB +: 4] <= digit;
        end
    end

endmodule

// File: rtl/cook_controller.sv
// cook_controller
// Top-level sequencer for the microwave timer datapath. Collects keypad
// digits into an MM:SS preset, loads and enables the external cascaded
// timer-digit chain, and runs the cook state machine that drives the
// magnetron and the end-of-cook beeper.
//
// Configuration macro: COOK_BEEP_EN
//   defined   - DONE holds the beeper on for BEEP_SECS sec_tick pulses
//   undefined - no beep counter, beep tied low, DONE lasts one cycle
//
// Parameters:
//   BEEP_SECS     number of sec_tick pulses the beeper stays on (1..15)
//
// Ports:
//   clk           system clock
//   clrn          asynchronous active-low reset (also resets timer chain)
//   sec_tick      one-cycle 1 Hz enable pulse
//   key_valid     one-cycle pulse, key_digit valid
//   key_digit     BCD digit from keypad
//   start         one-cycle debounced start pulse
//   stop          one-cycle debounced stop/clear pulse
//   door_closed   level, 1 = door closed
//   timer_zero    all timer digits are zero
//   preset        BCD preset, data input of the timer chain
//   timer_loadn   active-low parallel load of the timer chain
//   timer_en      count enable of the timer chain
//   magnetron_on  heating active
//   beep          beeper drive
//   entry_err     one-cycle pulse, start rejected for an invalid preset

module cook_controller #(
    parameter int BEEP_SECS = 3
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        sec_tick,
    input  logic        key_valid,
    input  logic [3:0]  key_digit,
    input  logic        start,
    input  logic        stop,
    input  logic        door_closed,
    input  logic        timer_zero,
    output logic [15:0] preset,
    output logic        timer_loadn,
    output logic        timer_en,
    output logic        magnetron_on,
    output logic        beep,
    output logic        entry_err
);
    import cook_pkg::*;

    cook_state_t state;

    logic digit_ok;
    logic nonzero;
    logic sec_tens_ok;
    logic entry_shift;
    logic entry_clear;
    logic start_ok;
    logic start_bad;
    logic done_exit;

    // A start in ENTRY swallows any key in the same cycle, and stop swallows
    // both, so digits only shift when neither button is pressed.
    assign entry_shift = key_valid &
                         ((state == ST_IDLE) |
                          ((state == ST_ENTRY) & ~start & ~stop));

    // The preset is wiped on abort from ENTRY, on stop from PAUSED (so it
    // already reads zero during CLEAR), and whenever DONE is left.
    assign entry_clear = (stop & ((state == ST_ENTRY) | (state == ST_PAUSED))) |
                         ((state == ST_DONE) & done_exit);

    assign start_ok  = door_closed & nonzero & sec_tens_ok;
    assign start_bad = nonzero & ~sec_tens_ok;

    cook_entry_reg u_entry (
        .clk         (clk),
        .clrn        (clrn),
        .shift       (entry_shift),
        .clear       (entry_clear),
        .digit       (key_digit),
        .preset      (preset),
        .digit_ok    (digit_ok),
        .nonzero     (nonzero),
        .sec_tens_ok (sec_tens_ok)
    );

`ifdef COOK_BEEP_EN
    localparam logic [3:0] BEEP_LAST = 4'(BEEP_SECS - 1);

    logic [3:0] beep_cnt;

    // DONE ends on the last beep tick, or early when the user stops or
    // opens the door.
    assign done_exit = stop | ~door_closed | (sec_tick & (beep_cnt == BEEP_LAST));
    assign beep      = (state == ST_DONE);

    // Beep counter: sits at zero outside DONE so every DONE visit starts a
    // fresh count.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            beep_cnt <= 4'd0;
        end else if ((state != ST_DONE) || done_exit) begin
            beep_cnt <= 4'd0;
        end else if (sec_tick) begin
            beep_cnt <= beep_cnt + 4'd1;
        end
    end
`else
    logic unused_beep_secs;

    assign done_exit        = 1'b1;
    assign beep             = 1'b0;
    assign unused_beep_secs = ^BEEP_SECS;
`endif

    // Cook state machine. entry_err is a registered one-cycle pulse that
    // follows a start rejected for seconds tens above 5.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= ST_IDLE;
            entry_err <= 1'b0;
        end else begin
            entry_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (key_valid && digit_ok) begin
                        state <= ST_ENTRY;
                    end
                end
                ST_ENTRY: begin
                    if (stop) begin
                        state <= ST_IDLE;
                    end else if (start) begin
                        if (start_ok) begin
                            state <= ST_LOAD;
                        end else if (start_bad) begin
                            entry_err <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    state <= ST_COOKING;
                end
                ST_COOKING: begin
                    // Reaching zero wins over a concurrent stop or door open
                    if (timer_zero) begin
                        state <= ST_DONE;
                    end else if (stop || !door_closed) begin
                        state <= ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    if (stop) begin
                        state <= ST_CLEAR;
                    end else if (start && door_closed) begin
                        state <= ST_COOKING;
                    end
                end
                ST_CLEAR: begin
                    state <= ST_IDLE;
                end
                ST_DONE: begin
                    if (done_exit) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // LOAD copies the preset into the chain; CLEAR copies the zeroed preset
    // in, which is how a stop from PAUSED empties the timer.
    assign timer_loadn  = ~((state == ST_LOAD) | (state == ST_CLEAR));
    assign timer_en     = (state == ST_LOAD) | (state == ST_CLEAR) |
                          ((state == ST_COOKING) & sec_tick);
    assign magnetron_on = (state == ST_COOKING);

endmodule

// File: tb/tb_cook_controller.sv
// tb_cook_controller
// Self-checking bench for cook_controller. A small stand-in for the timer
// chain (whole seconds remaining) supplies timer_zero, a behavioural model
// of the cook rules predicts every output each cycle, and directed
// sequences add literal expectations at key points.

module tb_cook_controller;

    localparam int BEEP_SECS = 3;

    logic        clk = 1'b0;
    logic        clrn;
    logic        sec_tick;
    logic        key_valid;
    logic [3:0]  key_digit;
    logic        start;
    logic        stop;
    logic        door_closed;
    logic        timer_zero;
    logic [15:0] preset;
    logic        timer_loadn;
    logic        timer_en;
    logic        magnetron_on;
    logic        beep;
    logic        entry_err;

    int checks = 0;
    int errors = 0;

    cook_controller #(.BEEP_SECS(BEEP_SECS)) dut (
        .clk          (clk),
        .clrn         (clrn),
        .sec_tick     (sec_tick),
        .key_valid    (key_valid),
        .key_digit    (key_digit),
        .start        (start),
        .stop         (stop),
        .door_closed  (door_closed),
        .timer_zero   (timer_zero),
        .preset       (preset),
        .timer_loadn  (timer_loadn),
        .timer_en     (timer_en),
        .magnetron_on (magnetron_on),
        .beep         (beep),
        .entry_err    (entry_err)
    );

    always #5 clk = ~clk;

    // Timer chain stand-in: remaining time as plain seconds
    int tmr_secs = 0;

    function automatic int preset_secs(input logic [15:0] p);
        return (int'(p[15:12]) * 10 + int'(p[11:8])) * 60 +
               int'(p[7:4]) * 10 + int'(p[3:0]);
    endfunction

    always @(posedge clk or negedge clrn) begin
        if (!clrn)
            tmr_secs <= 0;
        else if (!timer_loadn)
            tmr_secs <= preset_secs(preset);
        else if (timer_en && tmr_secs > 0)
            tmr_secs <= tmr_secs - 1;
    end

    assign timer_zero = (tmr_secs == 0);

    // Behavioural model of the cook rules
    string      m_mode = "IDLE";
    logic [3:0] m_dig[4] = '{4'd0, 4'd0, 4'd0, 4'd0};
    logic       m_err = 1'b0;
    int         m_beep_left = 0;

    function automatic void m_shift(input logic [3:0] d);
        m_dig[0] = m_dig[1];
        m_dig[1] = m_dig[2];
        m_dig[2] = m_dig[3];
        m_dig[3] = d;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
    endfunction

    function automatic logic m_nonzero();
        return (m_dig[0] != 0) || (m_dig[1] != 0) || (m_dig[2] != 0) || (m_dig[3] != 0);
    endfunction

    function automatic logic [15:0] m_preset();
        return {m_dig[0], m_dig[1], m_dig[2], m_dig[3]};
    endfunction

    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            m_mode = "IDLE";
            m_clear();
            m_err = 1'b0;
            m_beep_left = 0;
        end else begin
            m_err = 1'b0;
            if (m_mode == "IDLE") begin
                if (key_valid && key_digit <= 4'd9) begin
                    m_shift(key_digit);
                    m_mode = "ENTRY";
                end
            end else if (m_mode == "ENTRY") begin
                if (stop) begin
                    m_clear();
                    m_mode = "IDLE";
                end else if (start) begin
                    if (m_nonzero() && m_dig[2] > 4'd5)
                        m_err = 1'b1;
                    else if (m_nonzero() && door_closed)
                        m_mode = "LOAD";
                end else if (key_valid && key_digit <= 4'd9) begin
                    m_shift(key_digit);
                end
            end else if (m_mode == "LOAD") begin
                m_mode = "COOKING";
            end else if (m_mode == "COOKING") begin
                if (timer_zero) begin
                    m_mode = "DONE";
                    m_beep_left = BEEP_SECS;
                end else if (stop || !door_closed) begin
                    m_mode = "PAUSED";
                end
            end else if (m_mode == "PAUSED") begin
                if (stop) begin
                    m_clear();
                    m_mode = "CLEAR";
                end else if (start && door_closed) begin
                    m_mode = "COOKING";
                end
            end else if (m_mode == "CLEAR") begin
                m_mode = "IDLE";
            end else if (m_mode == "DONE") begin
`ifdef COOK_BEEP_EN
                if (stop || !door_closed) begin
                    m_clear();
                    m_mode = "IDLE";
                end else if (sec_tick) begin
                    m_beep_left = m_beep_left - 1;
                    if (m_beep_left == 0) begin
                        m_clear();
                        m_mode = "IDLE";
                    end
                end
`else
                m_clear();
                m_mode = "IDLE";
`endif
            end
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        logic exp_loadn;
        logic exp_en;
        logic exp_mag;
        logic exp_beep;
        exp_loadn = !((m_mode == "LOAD") || (m_mode == "CLEAR"));
        exp_en    = (m_mode == "LOAD") || (m_mode == "CLEAR") ||
                    ((m_mode == "COOKING") && sec_tick);
        exp_mag   = (m_mode == "COOKING");
`ifdef COOK_BEEP_EN
        exp_beep  = (m_mode == "DONE");
`else
        exp_beep  = 1'b0;
`endif
        checkOutput("model_preset", preset, m_preset());
        checkOutput("model_timer_loadn", 16'(timer_loadn), 16'(exp_loadn));
        checkOutput("model_timer_en", 16'(timer_en), 16'(exp_en));
        checkOutput("model_magnetron_on", 16'(magnetron_on), 16'(exp_mag));
        checkOutput("model_beep", 16'(beep), 16'(exp_beep));
        checkOutput("model_entry_err", 16'(entry_err), 16'(m_err));
    end

    // Drive one cycle of inputs; called and returning at posedge + 2
    task automatic applyStimulus(input logic kv, input logic [3:0] d,
                                 input logic st, input logic sp, input logic tk);
        key_valid = kv;
        key_digit = d;
        start     = st;
        stop      = sp;
        sec_tick  = tk;
        @(posedge clk);
        #2;
        key_valid = 1'b0;
        key_digit = 4'd0;
        start     = 1'b0;
        stop      = 1'b0;
        sec_tick  = 1'b0;
    endtask

    task automatic pressKey(input logic [3:0] d);
        applyStimulus(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clrn        = 1'b0;
        sec_tick    = 1'b0;
        key_valid   = 1'b0;
        key_digit   = 4'd0;
        start       = 1'b0;
        stop        = 1'b0;
        door_closed = 1'b1;
        @(posedge clk); #2;
        @(posedge clk); #2;

        checkOutput("reset_preset", preset, 16'h0000);
        checkOutput("reset_loadn", 16'(timer_loadn), 16'h0001);
        checkOutput("reset_en", 16'(timer_en), 16'h0000);
        checkOutput("reset_magnetron", 16'(magnetron_on), 16'h0000);
        clrn = 1'b1;
        idleCycle();

        // Keys 1,3,0 then start: LOAD for one cycle, then heating
        pressKey(4'd1);
        pressKey(4'd3);
        pressKey(4'd0);
        checkOutput("keys_130_preset", preset, 16'h0130);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("load_loadn", 16'(timer_loadn), 16'h0000);
        checkOutput("load_en", 16'(timer_en), 16'h0001);
        checkOutput("load_magnetron", 16'(magnetron_on), 16'h0000);
        idleCycle();
        checkOutput("cook_magnetron", 16'(magnetron_on), 16'h0001);
        checkOutput("cook_loadn", 16'(timer_loadn), 16'h0001);

        // Stop while cooking pauses, second stop clears the chain
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("paused_magnetron", 16'(magnetron_on), 16'h0000);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("clear_loadn", 16'(timer_loadn), 16'h0000);
        checkOutput("clear_preset", preset, 16'h0000);
        checkOutput("clear_en", 16'(timer_en), 16'h0001);
        idleCycle();
        checkOutput("after_clear_loadn", 16'(timer_loadn), 16'h0001);

        // Keys 0,7,5 then start: 75 seconds is not a legal MM:SS entry
        pressKey(4'd0);
        pressKey(4'd7);
        pressKey(4'd5);
        checkOutput("keys_075_preset", preset, 16'h0075);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("entry_err_pulse", 16'(entry_err), 16'h0001);
        checkOutput("entry_err_loadn", 16'(timer_loadn), 16'h0001);
        idleCycle();
        checkOutput("entry_err_end", 16'(entry_err), 16'h0000);
        checkOutput("entry_err_magnetron", 16'(magnetron_on), 16'h0000);
        checkOutput("entry_err_preset_kept", preset, 16'h0075);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("entry_stop_preset", preset, 16'h0000);

        // Start with the door open is ignored
        door_closed = 1'b0;
        pressKey(4'd5);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("door_open_start_loadn", 16'(timer_loadn), 16'h0001);
        checkOutput("door_open_start_preset", preset, 16'h0005);
        door_closed = 1'b1;

        // Cook 0x0005, open door after 2 ticks, resume, finish after 3 more
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        idleCycle();
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        door_closed = 1'b0;
        idleCycle();
        checkOutput("door_open_magnetron", 16'(magnetron_on), 16'h0000);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        door_closed = 1'b1;
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("resume_magnetron", 16'(magnetron_on), 16'h0001);
        checkOutput("resume_no_reload", 16'(timer_loadn), 16'h0001);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("before_done_magnetron", 16'(magnetron_on), 16'h0001);
        idleCycle();
        checkOutput("done_magnetron", 16'(magnetron_on), 16'h0000);
`ifdef COOK_BEEP_EN
        checkOutput("done_beep", 16'(beep), 16'h0001);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("beep_tick2", 16'(beep), 16'h0001);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("beep_over", 16'(beep), 16'h0000);
`else
        checkOutput("done_beep", 16'(beep), 16'h0000);
        checkOutput("done_preset_held", preset, 16'h0005);
        idleCycle();
`endif
        checkOutput("after_done_preset", preset, 16'h0000);

        // Non-BCD key ignored; start+stop together in ENTRY aborts
        pressKey(4'hB);
        checkOutput("bad_key_preset", preset, 16'h0000);
        pressKey(4'd4);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        checkOutput("start_stop_preset", preset, 16'h0000);
        checkOutput("start_stop_loadn", 16'(timer_loadn), 16'h0001);

        // Start drops a same-cycle key (door open so start is ignored)
        pressKey(4'd1);
        door_closed = 1'b0;
        applyStimulus(1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
        checkOutput("start_drops_key", preset, 16'h0001);
        door_closed = 1'b1;

        // timer_zero wins over stop in COOKING
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        idleCycle();
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("zero_beats_stop_mag", 16'(magnetron_on), 16'h0000);
`ifdef COOK_BEEP_EN
        checkOutput("zero_beats_stop_beep", 16'(beep), 16'h0001);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
`else
        idleCycle();
`endif
        checkOutput("zero_beats_stop_preset", preset, 16'h0000);
        checkOutput("zero_beats_stop_loadn", 16'(timer_loadn), 16'h0001);

        // clrn mid-cook returns every output to its reset value at once
        pressKey(4'd2);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        idleCycle();
        checkOutput("precrash_magnetron", 16'(magnetron_on), 16'h0001);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        clrn = 1'b0;
        #1;
        checkOutput("clrn_magnetron", 16'(magnetron_on), 16'h0000);
        checkOutput("clrn_loadn", 16'(timer_loadn), 16'h0001);
        checkOutput("clrn_en", 16'(timer_en), 16'h0000);
        checkOutput("clrn_preset", preset, 16'h0000);
        checkOutput("clrn_beep", 16'(beep), 16'h0000);
        checkOutput("clrn_entry_err", 16'(entry_err), 16'h0000);
        @(posedge clk); #2;
        clrn = 1'b1;
        idleCycle();
        idleCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
